// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract/accumulate stream unit.
// Holds the 2-bit operation codes and the operation type used by
// addsub_acc_stream and addsub_sat_unit.
package addsub_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD  = 2'b00;
  localparam op_t OP_SUB  = 2'b01;
  localparam op_t OP_ACC  = 2'b10;
  localparam op_t OP_LOAD = 2'b11;

endpackage

// File: rtl/addsub_sat_unit.sv
// Combinational add/subtract core with optional unsigned saturation.
// Ports:
//   op      operation code (addsub_pkg OP_*)
//   lhs     left operand (accumulator for ACC, operand A otherwise)
//   rhs     right operand (operand A for ACC, operand B otherwise)
//   result  final result after optional clamp
//   carry   raw unsigned carry (ADD/ACC) or borrow (SUB)
//   ovf     raw two's-complement overflow
//   sat     clamp was applied (always 0 when SATURATE=0)
module addsub_sat_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             sat
);

  // Clamp high on carry-out, low on borrow; pass-through when wrapping.
  function automatic logic [WIDTH-1:0] sat_clamp(
    input logic [WIDTH-1:0] raw,
    input logic             hi,
    input logic             lo
  );
    if (SATURATE && hi) return '1;
    if (SATURATE && lo) return '0;
    return raw;
  endfunction

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] sum_raw;
  logic [WIDTH-1:0] diff_raw;

  assign sum      = {1'b0, lhs} + {1'b0, rhs};
  assign diff     = {1'b0, lhs} - {1'b0, rhs};
  assign sum_raw  = sum[WIDTH-1:0];
  assign diff_raw = diff[WIDTH-1:0];

  always_comb begin
    result = lhs;
    carry  = 1'b0;
    ovf    = 1'b0;
    sat    = 1'b0;
    case (op_t'(op))
      OP_ADD, OP_ACC: begin
        carry  = sum[WIDTH];
        ovf    = (lhs[WIDTH-1] == rhs[WIDTH-1]) && (sum_raw[WIDTH-1] != lhs[WIDTH-1]);
        result = sat_clamp(sum_raw, sum[WIDTH], 1'b0);
        sat    = SATURATE && sum[WIDTH];
      end
      OP_SUB: begin
        // The extra MSB of the widened difference is the unsigned borrow.
        carry  = diff[WIDTH];
        ovf    = (lhs[WIDTH-1] != rhs[WIDTH-1]) && (diff_raw[WIDTH-1] != lhs[WIDTH-1]);
        result = sat_clamp(diff_raw, 1'b0, diff[WIDTH]);
        sat    = SATURATE && diff[WIDTH];
      end
      default: begin
        result = lhs;
      end
    endcase
  end

endmodule

// File: rtl/addsub_acc_stream.sv
// Registered add/subtract/accumulate unit with valid/ready streams.
// One-cycle latency, full throughput, output held under backpressure.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          input handshake (in_ready has no in_valid path)
//   in_op, in_a, in_b          operation and operands
//   out_valid/out_ready        output handshake
//   out_data                   result
//   out_carry/out_ovf          raw carry/borrow and signed overflow
//   out_zero/out_sat           result-is-zero and clamp-applied flags
//   acc_value                  accumulator contents
//   op_count                   accepted-beat counter, wraps at 2^CNT_W
module addsub_acc_stream
  import addsub_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_sat,
  output logic [WIDTH-1:0] acc_value,
  output logic [CNT_W-1:0] op_count
);

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic             carry_p1;
  logic             ovf_p1;
  logic             zero_p1;
  logic             sat_p1;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             is_acc;
  logic [WIDTH-1:0] lhs_p0;
  logic [WIDTH-1:0] rhs_p0;
  logic [WIDTH-1:0] res_p0;
  logic             carry_p0;
  logic             ovf_p0;
  logic             sat_p0;

  // Stage p0: handshake and combinational compute
  assign in_ready = ~reset & (~vld_p1 | out_ready);
  assign accept   = in_valid & in_ready;
  assign is_acc   = (op_t'(in_op) == OP_ACC);
  assign lhs_p0   = is_acc ? acc_q : in_a;
  assign rhs_p0   = is_acc ? in_a  : in_b;

  addsub_sat_unit #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_sat_unit (
    .op     (in_op),
    .lhs    (lhs_p0),
    .rhs    (rhs_p0),
    .result (res_p0),
    .carry  (carry_p0),
    .ovf    (ovf_p0),
    .sat    (sat_p0)
  );

  // Stage p1: output register, accumulator and counter
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      carry_p1 <= 1'b0;
      ovf_p1   <= 1'b0;
      zero_p1  <= 1'b0;
      sat_p1   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      data_p1  <= res_p0;
      carry_p1 <= carry_p0;
      ovf_p1   <= ovf_p0;
      zero_p1  <= (res_p0 == '0);
      sat_p1   <= sat_p0;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (is_acc || (op_t'(in_op) == OP_LOAD)) acc_q <= res_p0;
    end else if (out_ready) begin
      // Drained with nothing new: drop valid, keep the last data visible.
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_carry = carry_p1;
  assign out_ovf   = ovf_p1;
  assign out_zero  = zero_p1;
  assign out_sat   = sat_p1;
  assign acc_value = acc_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_addsub_acc_stream.sv
module tb_addsub_acc_stream;

  localparam logic [1:0] ADD  = 2'b00;
  localparam logic [1:0] SUB  = 2'b01;
  localparam logic [1:0] ACC  = 2'b10;
  localparam logic [1:0] LOAD = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       out_ready;
  logic [1:0] in_op;
  logic [7:0] in_a;
  logic [7:0] in_b;

  logic       w_in_ready, w_out_valid, w_carry, w_ovf, w_zero, w_sat;
  logic [7:0] w_data, w_acc, w_cnt;
  logic       s_in_ready, s_out_valid, s_carry, s_ovf, s_zero, s_sat;
  logic [7:0] s_data, s_acc, s_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  addsub_acc_stream #(.WIDTH(8), .SATURATE(1'b0), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_data),
    .out_carry(w_carry), .out_ovf(w_ovf), .out_zero(w_zero), .out_sat(w_sat),
    .acc_value(w_acc), .op_count(w_cnt)
  );

  addsub_acc_stream #(.WIDTH(8), .SATURATE(1'b1), .CNT_W(8)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_data),
    .out_carry(s_carry), .out_ovf(s_ovf), .out_zero(s_zero), .out_sat(s_sat),
    .acc_value(s_acc), .op_count(s_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One accepted beat; outputs are sampled 1 time unit after the edge.
  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_op = ADD; in_a = 8'h00; in_b = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    check("rst_valid", w_out_valid, 0);
    check("rst_data", w_data, 0);
    check("rst_flags", {w_carry, w_ovf, w_zero, w_sat}, 0);
    check("rst_acc", w_acc, 0);
    check("rst_cnt", w_cnt, 0);
    check("rst_ready", w_in_ready, 0);
    reset = 1'b0;
    #1;
    check("ready_idle", w_in_ready, 1);

    send(ADD, 8'h0F, 8'h01);
    check("add_valid", w_out_valid, 1);
    check("add_data", w_data, 8'h10);
    check("add_flags", {w_carry, w_ovf, w_zero, w_sat}, 4'b0000);
    check("add_cnt", w_cnt, 1);

    send(ADD, 8'hFF, 8'h01);
    check("wrap_data", w_data, 8'h00);
    check("wrap_flags", {w_carry, w_zero, w_sat}, 3'b110);
    check("sat_add_data", s_data, 8'hFF);
    check("sat_add_flags", {s_carry, s_zero, s_sat}, 3'b101);

    send(SUB, 8'h05, 8'h07);
    check("sat_sub_data", s_data, 8'h00);
    check("sat_sub_flags", {s_carry, s_zero, s_sat}, 3'b111);
    check("wrap_sub_data", w_data, 8'hFE);
    check("wrap_sub_flags", {w_carry, w_sat}, 2'b10);

    send(ADD, 8'h7F, 8'h01);
    check("ovf_add_data", w_data, 8'h80);
    check("ovf_add_flags", {w_carry, w_ovf}, 2'b01);

    send(SUB, 8'h80, 8'h01);
    check("ovf_sub_data", w_data, 8'h7F);
    check("ovf_sub_flags", {w_carry, w_ovf}, 2'b01);

    send(LOAD, 8'h10, 8'hAA);
    check("load_data", w_data, 8'h10);
    check("load_acc", w_acc, 8'h10);
    send(ACC, 8'h20, 8'h55);
    check("acc1_data", w_data, 8'h30);
    check("acc1_acc", w_acc, 8'h30);
    send(ADD, 8'h01, 8'h01);
    check("mid_add_data", w_data, 8'h02);
    check("mid_add_acc", w_acc, 8'h30);
    send(ACC, 8'hF0, 8'h00);
    check("acc2_data", w_data, 8'h20);
    check("acc2_carry", w_carry, 1);
    check("acc2_acc", w_acc, 8'h20);
    check("sat_acc", s_acc, 8'hFF);
    check("sat_acc_flag", s_sat, 1);
    check("cnt9", w_cnt, 9);

    // Drain with no new beat: valid drops, data holds.
    @(posedge clk); #1;
    check("drain_valid", w_out_valid, 0);
    check("drain_data", w_data, 8'h20);

    // Backpressure
    send(ADD, 8'h01, 8'h02);
    check("bp_first", w_data, 8'h03);
    out_ready = 1'b0; in_valid = 1'b1; in_op = ADD; in_a = 8'h05; in_b = 8'h05;
    #1;
    check("bp_ready0", w_in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_hold_ready", w_in_ready, 0);
      check("bp_hold_data", w_data, 8'h03);
      check("bp_hold_valid", w_out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", w_in_ready, 1);
    @(posedge clk); #1;
    check("bp_next_valid", w_out_valid, 1);
    check("bp_next_data", w_data, 8'h0A);
    check("bp_cnt", w_cnt, 11);

    // Stream 289 more beats back-to-back: 300 accepted in total.
    for (int i = 0; i < 289; i++) begin
      in_op = ADD; in_a = 8'(i); in_b = 8'h01; in_valid = 1'b1;
      @(posedge clk); #1;
      if (i == 144) check("stream_valid", w_out_valid, 1);
    end
    check("stream_last", w_data, 8'h21);
    check("stream_cnt", w_cnt, 44);

    // Reset while a result is pending
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("pre_rst_valid", w_out_valid, 1);
    reset = 1'b1;
    #1;
    check("rst_hi_ready", w_in_ready, 0);
    @(posedge clk); #1;
    check("mid_rst_valid", w_out_valid, 0);
    check("mid_rst_acc", w_acc, 0);
    check("mid_rst_cnt", w_cnt, 0);
    check("mid_rst_sat_acc", s_acc, 0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_acc_stream.md
Name: addsub_acc_stream

Overview:
Parametrised, registered add/subtract/accumulate unit with a valid/ready stream interface on input and output. It is the successor to the fixed 4-bit registered adder and replaces it in the design's datapath. It adds:
- width parameter and optional unsigned saturation
- a persistent accumulator and a transaction counter
- backpressure on the output
- carry, overflow, zero and saturation flags

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
SATURATE, 0, 1 = unsigned clamp on carry/borrow; 0 = modular wrap
CNT_W, 8, width of accepted-transaction counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  unit can accept a beat this cycle
in_op  in  2  operation code (see package)
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B (ignored for ACC/LOAD)
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
out_data  out  WIDTH  result
out_carry  out  1  raw unsigned carry (ADD/ACC) or borrow (SUB)
out_ovf  out  1  raw two's-complement overflow
out_zero  out  1  out_data == 0
out_sat  out  1  clamp applied (always 0 when SATURATE=0)
acc_value  out  WIDTH  current accumulator contents
op_count  out  CNT_W  number of accepted beats, modulo 2^CNT_W

Behaviour:
- Reset (sampled at clk edge while reset=1): out_valid=0, out_data=0, all flags=0, acc=0, op_count=0. Any pending result is dropped.
- in_ready = ~reset & (~out_valid | out_ready). It is combinational and has no path from in_valid.
- Accept = in_valid & in_ready. Latency is 1 cycle: the result is registered, and out_valid=1 on the edge after accept.
- Output hold: while out_valid & ~out_ready, out_data and all flags stay stable and no beat is accepted.
- Simultaneous out_ready=1 and a new accept on the same cycle: the register is replaced on that edge, with no bubble, giving full throughput.
- out_ready=1 with no accept: out_valid falls to 0 on the next edge. out_data keeps its last value.
- Operations:
  - ADD (00): raw = a+b. carry = bit WIDTH of the sum. ovf = signs of a and b equal and sign of raw differs.
  - SUB (01): raw = a-b. carry = borrow (a<b unsigned). ovf = signs of a and b differ and sign of raw differs from a.
  - ACC (10): raw = acc+a with ADD flag rules. acc <= final result.
  - LOAD (11): result = a. carry=ovf=sat=0. acc <= a.
- Saturation (SATURATE=1):
  - ADD/ACC with carry: result = all ones, sat=1.
  - SUB with borrow: result = 0, sat=1.
  - carry and ovf still report raw values.
- Wrap (SATURATE=0): the result is the low WIDTH bits of raw, so the accumulator wraps modulo 2^WIDTH.
- acc updates only on an accepted ACC or LOAD. ADD and SUB never touch acc.
- op_count increments on each accept and wraps from all-ones to 0.
- out_zero is computed on the final (post-saturation) result.
- in_op, in_a and in_b are don't-care when not accepted.

Decomposition:
- Shared package addsub_pkg holds:
  - localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_ACC=2'b10, OP_LOAD=2'b11
  - a 2-bit op typedef
- Sub-module addsub_sat_unit (purely combinational, parametrised by WIDTH and SATURATE):
  - inputs: op, lhs, rhs
  - outputs: result, carry, ovf, sat
  - the top selects lhs = acc for ACC
- The top holds the handshake, output register, acc and counter.

Test Plan (WIDTH=8, CNT_W=8):
- ADD 0x0F+0x01, out_ready=1 -> next cycle out_valid=1, out_data=0x10, carry=0, ovf=0, zero=0, op_count=1.
- SATURATE=0: ADD 0xFF+0x01 -> out_data=0x00, carry=1, zero=1, sat=0. SATURATE=1: same stimulus -> out_data=0xFF, carry=1, sat=1. SATURATE=1: SUB 0x05-0x07 -> out_data=0x00, carry=1, sat=1.
- Signed overflow: ADD 0x7F+0x01 -> out_data=0x80, ovf=1, carry=0. SUB 0x80-0x01 -> out_data=0x7F, ovf=1.
- Accumulate, SATURATE=0: LOAD 0x10, then ACC 0x20, then ACC 0xF0 -> out_data 0x10, 0x30, 0x20 (carry=1 on the last), acc_value=0x20. An interleaved ADD 1+1 leaves acc_value unchanged.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_data stable. Then set out_ready=1 -> the next beat is accepted on the same edge and out_valid stays high. Streaming 300 beats -> op_count wraps to 44.
- Reset mid-stream with out_valid=1 -> out_valid=0, acc_value=0, op_count=0 after the edge, and in_ready=0 while reset is high.
